mips_pipe_ctrl: RTL and testbench

Parametrised successor to the five-stage MIPS control unit: decodes the instruction in D, carries the control bits through registered E/M/W stages, and adds the hazard unit (forwarding selects, load-use and branch interlocks, E-stage bubble insertion). It sits beside the pipelined datapath, which supplies register numbers and the D-stage equality result and consumes every output below.

---
 rtl/mips_pipe_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_ctrl.sv
`timescale 1ns/1ps
// mips_pipe_ctrl
// Control and hazard unit for a five-stage MIPS pipeline. Decodes the
// instruction in D, carries the control bits through registered E/M/W stages
// and produces forwarding selects, load-use/branch interlocks and the E-stage
// bubble (FlushE).
//
// Parameters
//   AW      register-address width
//   FWD_EN  1: forwarding with minimal stalls; 0: no forwarding, stall on RAW
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   OpD, FunctD, EqualD      D-stage opcode, funct, rs==rt compare result
//   RsD, RtD, RsE, RtE       source register numbers in D and E
//   WriteRegE/M/W            destination register numbers in E, M, W
//   PCSrcD                   take branch target
//   StallD, FlushE           hold F/D, clear ID/EX
//   ForwardAD, ForwardBD     D-compare operands from ALUOut of M
//   ForwardAE, ForwardBE     E operand selects (00 RF, 01 W result, 10 M ALUOut)
//   RegDstE, ALUSrcE, ALUControlE, MemWriteM, RegWriteW, MemtoRegW
//                            registered control bits for the datapath
module mips_pipe_ctrl #(
    parameter int AW     = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    OpD,
    input  logic [5:0]    FunctD,
    input  logic          EqualD,
    input  logic [AW-1:0] RsD,
    input  logic [AW-1:0] RtD,
    input  logic [AW-1:0] RsE,
    input  logic [AW-1:0] RtE,
    input  logic [AW-1:0] WriteRegE,
    input  logic [AW-1:0] WriteRegM,
    input  logic [AW-1:0] WriteRegW,
    output logic          PCSrcD,
    output logic          StallD,
    output logic          FlushE,
    output logic          ForwardAD,
    output logic          ForwardBD,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          RegDstE,
    output logic          ALUSrcE,
    output logic [2:0]    ALUControlE,
    output logic          MemWriteM,
    output logic          RegWriteW,
    output logic          MemtoRegW
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // D-stage decode
    logic       reg_write_d, mem_to_reg_d, mem_write_d;
    logic       alu_src_d, reg_dst_d, beq_d, bne_d;
    logic [2:0] alu_ctrl_d;

    always_comb begin
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        reg_dst_d    = 1'b0;
        beq_d        = 1'b0;
        bne_d        = 1'b0;
        alu_ctrl_d   = 3'b000;
        case (OpD)
            OP_RTYPE: begin
                // unknown funct (including nop) leaves every bit cleared
                case (FunctD)
                    FN_ADD: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_ADD; end
                    FN_SUB: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_SUB; end
                    FN_AND: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_AND; end
                    FN_OR:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_OR;  end
                    FN_SLT: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LW: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                alu_src_d    = 1'b1;
                alu_ctrl_d   = ALU_ADD;
            end
            OP_SW: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_ctrl_d  = ALU_ADD;
            end
            OP_ADDI: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_ctrl_d  = ALU_ADD;
            end
            OP_BEQ: beq_d = 1'b1;
            OP_BNE: bne_d = 1'b1;
            default: ;
        endcase
    end

    // Stage registers
    logic       reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e;
    logic [2:0] alu_ctrl_e;
    logic       reg_write_m, mem_to_reg_m, mem_write_m;
    logic       reg_write_w, mem_to_reg_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            mem_write_e  <= 1'b0;
            alu_src_e    <= 1'b0;
            reg_dst_e    <= 1'b0;
            alu_ctrl_e   <= 3'b000;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end else begin
            if (FlushE) begin
                reg_write_e  <= 1'b0;
                mem_to_reg_e <= 1'b0;
                mem_write_e  <= 1'b0;
                alu_src_e    <= 1'b0;
                reg_dst_e    <= 1'b0;
                alu_ctrl_e   <= 3'b000;
            end else begin
                reg_write_e  <= reg_write_d;
                mem_to_reg_e <= mem_to_reg_d;
                mem_write_e  <= mem_write_d;
                alu_src_e    <= alu_src_d;
                reg_dst_e    <= reg_dst_d;
                alu_ctrl_e   <= alu_ctrl_d;
            end
            reg_write_m  <= reg_write_e;
            mem_to_reg_m <= mem_to_reg_e;
            mem_write_m  <= mem_write_e;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
        end
    end

    // Forwarding: M has priority over W since it holds the newer value.
    logic [1:0] fwd_ae, fwd_be;
    logic       fwd_ad, fwd_bd;

    always_comb begin
        fwd_ae = 2'b00;
        if (RsE != '0 && RsE == WriteRegM && reg_write_m)
            fwd_ae = 2'b10;
        else if (RsE != '0 && RsE == WriteRegW && reg_write_w)
            fwd_ae = 2'b01;
        fwd_be = 2'b00;
        if (RtE != '0 && RtE == WriteRegM && reg_write_m)
            fwd_be = 2'b10;
        else if (RtE != '0 && RtE == WriteRegW && reg_write_w)
            fwd_be = 2'b01;
    end

    assign fwd_ad = (RsD != '0) && (RsD == WriteRegM) && reg_write_m;
    assign fwd_bd = (RtD != '0) && (RtD == WriteRegM) && reg_write_m;

    // Interlocks with forwarding
    logic branch_d, lw_stall, branch_stall, stall_fwd;

    assign branch_d     = beq_d | bne_d;
    assign lw_stall     = mem_to_reg_e && (RtE == RsD || RtE == RtD);
    assign branch_stall = branch_d &&
                          ((reg_write_e  && (WriteRegE == RsD || WriteRegE == RtD)) ||
                           (mem_to_reg_m && (WriteRegM == RsD || WriteRegM == RtD)));
    assign stall_fwd    = lw_stall | branch_stall;

    // Interlocks without forwarding: wait until the producer has left W.
    logic hit_e, hit_m, hit_w, stall_nofwd;

    assign hit_e = reg_write_e && (WriteRegE != '0) && (WriteRegE == RsD || WriteRegE == RtD);
    assign hit_m = reg_write_m && (WriteRegM != '0) && (WriteRegM == RsD || WriteRegM == RtD);
    assign hit_w = reg_write_w && (WriteRegW != '0) && (WriteRegW == RsD || WriteRegW == RtD);
    assign stall_nofwd = hit_e | hit_m | hit_w;

    assign StallD    = FWD_EN ? stall_fwd : stall_nofwd;
    assign FlushE    = StallD;
    assign ForwardAE = FWD_EN ? fwd_ae : 2'b00;
    assign ForwardBE = FWD_EN ? fwd_be : 2'b00;
    assign ForwardAD = FWD_EN ? fwd_ad : 1'b0;
    assign ForwardBD = FWD_EN ? fwd_bd : 1'b0;

    // A stalled branch is re-evaluated once its operands are ready.
    assign PCSrcD = ~StallD & ((beq_d & EqualD) | (bne_d & ~EqualD));

    assign RegDstE     = reg_dst_e;
    assign ALUSrcE     = alu_src_e;
    assign ALUControlE = alu_ctrl_e;
    assign MemWriteM   = mem_write_m;
    assign RegWriteW   = reg_write_w;
    assign MemtoRegW   = mem_to_reg_w;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
`timescale 1ns/1ps
// tb_mips_pipe_ctrl
// Bench for mips_pipe_ctrl: a forwarding instance and a no-forwarding
// instance, each beside a small register-number pipeline standing in for the
// datapath. Decode table sweep with queued per-stage expectations, plus
// hand-written hazard and reset sequences.
module tb_mips_pipe_ctrl;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] FADD = 6'b100000;
    localparam logic [5:0] FSUB = 6'b100010;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // forwarding instance
    logic [5:0] op_d, funct_d;
    logic       eq_d;
    logic [4:0] rs_d, rt_d, dest_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       pcsrc, stall, flush, fad, fbd, reg_dst_e, alu_src_e;
    logic       mem_write_m, reg_write_w, mem_to_reg_w;
    logic [1:0] fae, fbe;
    logic [2:0] alu_e;

    // no-forwarding instance
    logic [5:0] op_d0, funct_d0;
    logic       eq_d0;
    logic [4:0] rs_d0, rt_d0, dest_d0, rs_e0, rt_e0, wr_e0, wr_m0, wr_w0;
    logic       pcsrc0, stall0, flush0, fad0, fbd0, reg_dst_e0, alu_src_e0;
    logic       mem_write_m0, reg_write_w0, mem_to_reg_w0;
    logic [1:0] fae0, fbe0;
    logic [2:0] alu_e0;

    mips_pipe_ctrl #(.AW(5), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .OpD(op_d), .FunctD(funct_d), .EqualD(eq_d),
        .RsD(rs_d), .RtD(rt_d), .RsE(rs_e), .RtE(rt_e),
        .WriteRegE(wr_e), .WriteRegM(wr_m), .WriteRegW(wr_w),
        .PCSrcD(pcsrc), .StallD(stall), .FlushE(flush),
        .ForwardAD(fad), .ForwardBD(fbd), .ForwardAE(fae), .ForwardBE(fbe),
        .RegDstE(reg_dst_e), .ALUSrcE(alu_src_e), .ALUControlE(alu_e),
        .MemWriteM(mem_write_m), .RegWriteW(reg_write_w), .MemtoRegW(mem_to_reg_w)
    );

    mips_pipe_ctrl #(.AW(5), .FWD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .OpD(op_d0), .FunctD(funct_d0), .EqualD(eq_d0),
        .RsD(rs_d0), .RtD(rt_d0), .RsE(rs_e0), .RtE(rt_e0),
        .WriteRegE(wr_e0), .WriteRegM(wr_m0), .WriteRegW(wr_w0),
        .PCSrcD(pcsrc0), .StallD(stall0), .FlushE(flush0),
        .ForwardAD(fad0), .ForwardBD(fbd0), .ForwardAE(fae0), .ForwardBE(fbe0),
        .RegDstE(reg_dst_e0), .ALUSrcE(alu_src_e0), .ALUControlE(alu_e0),
        .MemWriteM(mem_write_m0), .RegWriteW(reg_write_w0), .MemtoRegW(mem_to_reg_w0)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       eq;
        logic [2:0] alu;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pcsrc;
    } vec_t;

    typedef struct {
        int         due;
        logic [7:0] val;
        string      name;
    } exp_t;

    vec_t vecs[15];
    exp_t q_e[$], q_m[$], q_w[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_d(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dst, input logic eq);
        op_d = op; funct_d = fn; rs_d = rs; rt_d = rt; dest_d = dst; eq_d = eq;
    endtask

    task automatic set_d0(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] dst, input logic eq);
        op_d0 = op; funct_d0 = fn; rs_d0 = rs; rt_d0 = rt; dest_d0 = dst; eq_d0 = eq;
    endtask

    task automatic clear_pipes();
        rs_e = 0; rt_e = 0; wr_e = 0; wr_m = 0; wr_w = 0;
        rs_e0 = 0; rt_e0 = 0; wr_e0 = 0; wr_m0 = 0; wr_w0 = 0;
    endtask

    // One clock: register numbers move down the stand-in datapath, then the
    // queued stage expectations that fall due are compared.
    task automatic step();
        logic f, f0;
        exp_t x;
        @(negedge clk);
        f  = flush;
        f0 = flush0;
        @(posedge clk);
        #1;
        wr_w = wr_m; wr_m = wr_e;
        if (f) begin rs_e = 0; rt_e = 0; wr_e = 0; end
        else   begin rs_e = rs_d; rt_e = rt_d; wr_e = dest_d; end
        wr_w0 = wr_m0; wr_m0 = wr_e0;
        if (f0) begin rs_e0 = 0; rt_e0 = 0; wr_e0 = 0; end
        else    begin rs_e0 = rs_d0; rt_e0 = rt_d0; wr_e0 = dest_d0; end
        cycle++;
        #1;
        while (q_e.size() > 0 && q_e[0].due <= cycle) begin
            x = q_e.pop_front();
            chk(x.name, {alu_e, alu_src_e, reg_dst_e}, x.val);
        end
        while (q_m.size() > 0 && q_m[0].due <= cycle) begin
            x = q_m.pop_front();
            chk(x.name, mem_write_m, x.val);
        end
        while (q_w.size() > 0 && q_w[0].due <= cycle) begin
            x = q_w.pop_front();
            chk(x.name, {reg_write_w, mem_to_reg_w}, x.val);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_d(0, 0, 0, 0, 0, 0);
        set_d0(0, 0, 0, 0, 0, 0);
        clear_pipes();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //               op     funct      eq    alu   src dst mw rw m2r pc
        vecs[0]  = '{R,    6'b100000, 1'b0, 3'b010, 0, 1, 0, 1, 0, 0};
        vecs[1]  = '{R,    6'b100010, 1'b0, 3'b110, 0, 1, 0, 1, 0, 0};
        vecs[2]  = '{R,    6'b100100, 1'b0, 3'b000, 0, 1, 0, 1, 0, 0};
        vecs[3]  = '{R,    6'b100101, 1'b0, 3'b001, 0, 1, 0, 1, 0, 0};
        vecs[4]  = '{R,    6'b101010, 1'b0, 3'b111, 0, 1, 0, 1, 0, 0};
        vecs[5]  = '{R,    6'b000001, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{R,    6'b000000, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{LW,   6'b100010, 1'b0, 3'b010, 1, 0, 0, 1, 1, 0};
        vecs[8]  = '{SW,   6'b000000, 1'b0, 3'b010, 1, 0, 1, 0, 0, 0};
        vecs[9]  = '{ADDI, 6'b000000, 1'b0, 3'b010, 1, 0, 0, 1, 0, 0};
        vecs[10] = '{BEQ,  6'b000000, 1'b1, 3'b000, 0, 0, 0, 0, 0, 1};
        vecs[11] = '{BEQ,  6'b000000, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{BNE,  6'b000000, 1'b1, 3'b000, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{BNE,  6'b000000, 1'b0, 3'b000, 0, 0, 0, 0, 0, 1};
        vecs[14] = '{6'b111111, 6'b100000, 1'b1, 3'b000, 0, 0, 0, 0, 0, 0};

        // reset state
        rst = 1'b1;
        set_d(0, 0, 0, 0, 0, 0);
        set_d0(0, 0, 0, 0, 0, 0);
        clear_pipes();
        @(negedge clk);
        chk("reset_regs", {alu_e, alu_src_e, reg_dst_e, mem_write_m, reg_write_w, mem_to_reg_w}, 0);
        chk("reset_hazard", {pcsrc, stall, flush, fad, fbd, fae, fbe}, 0);
        chk("reset_regs_nofwd", {alu_e0, alu_src_e0, reg_dst_e0, mem_write_m0, reg_write_w0, mem_to_reg_w0}, 0);
        do_reset();

        // decode sweep: register numbers chosen so no hazard ever fires
        for (int i = 0; i < 15; i++) begin
            set_d(vecs[i].op, vecs[i].funct, 5'(16 + i), 5'(1 + i), 5'(1 + i), vecs[i].eq);
            #1;
            chk($sformatf("pcsrc_vec%0d", i), {stall, pcsrc}, {1'b0, vecs[i].pcsrc});
            q_e.push_back('{cycle + 1, {3'b000, vecs[i].alu, vecs[i].alu_src, vecs[i].reg_dst},
                            $sformatf("e_vec%0d", i)});
            q_m.push_back('{cycle + 2, {7'b0, vecs[i].mem_write}, $sformatf("m_vec%0d", i)});
            q_w.push_back('{cycle + 3, {6'b0, vecs[i].reg_write, vecs[i].mem_to_reg},
                            $sformatf("w_vec%0d", i)});
            step();
        end
        set_d(0, 0, 0, 0, 0, 0);
        repeat (4) step();

        // load-use: lw $2,($1) ; add $3,$2,$4
        do_reset();
        set_d(LW, 0, 1, 2, 2, 0);
        step();
        set_d(R, FADD, 2, 4, 3, 0);
        #1;
        chk("lu_stall", {stall, flush}, 2'b11);
        step();
        chk("lu_stall_clear", {stall, flush}, 2'b00);
        step();
        chk("lu_fwd_ae", fae, 2'b01);
        chk("lu_fwd_be", fbe, 2'b00);
        set_d(0, 0, 0, 0, 0, 0);
        step();
        chk("lu_bubble_w", reg_write_w, 1'b0);
        step();
        chk("lu_add_w", {reg_write_w, mem_to_reg_w}, 2'b10);

        // back-to-back ALU, M beats W, $0 never forwarded
        do_reset();
        set_d(R, FADD, 1, 2, 5, 0);
        step();
        set_d(R, FADD, 3, 4, 5, 0);
        step();
        set_d(R, FSUB, 5, 5, 6, 0);
        #1;
        chk("alu_nostall", stall, 1'b0);
        step();
        chk("alu_fwd", {fae, fbe}, 4'b1010);
        set_d(R, FADD, 1, 2, 0, 0);
        step();
        set_d(R, FSUB, 0, 0, 6, 0);
        step();
        chk("zero_fwd", {fae, fbe}, 4'b0000);

        // branch interlock: addi $1 ; beq $1,$1
        do_reset();
        set_d(ADDI, 0, 0, 1, 1, 0);
        step();
        set_d(BEQ, 0, 1, 1, 0, 1);
        #1;
        chk("br_stall", {stall, pcsrc}, 2'b10);
        step();
        chk("br_stall_clear", stall, 1'b0);
        chk("br_fwd_d", {fad, fbd}, 2'b11);
        chk("br_taken", pcsrc, 1'b1);
        set_d(BNE, 0, 1, 1, 0, 1);
        #1;
        chk("bne_not_taken", pcsrc, 1'b0);
        // lw $1 ; beq $1,$1 waits for lw to leave M
        set_d(LW, 0, 0, 1, 1, 0);
        step();
        set_d(BEQ, 0, 1, 1, 0, 1);
        #1;
        chk("lwbr_stall1", stall, 1'b1);
        step();
        chk("lwbr_stall2", {stall, pcsrc}, 2'b10);
        step();
        chk("lwbr_taken", {stall, pcsrc}, 2'b01);

        // no forwarding: add $5 ; sub $6,$5,$5 stalls three cycles
        do_reset();
        set_d0(R, FADD, 1, 2, 5, 0);
        #1;
        chk("nf_first", stall0, 1'b0);
        step();
        set_d0(R, FSUB, 5, 5, 6, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("nf_stall%0d", k), {stall0, flush0}, 2'b11);
            chk($sformatf("nf_fwd%0d", k), {fad0, fbd0, fae0, fbe0}, 6'b0);
            step();
        end
        chk("nf_release", stall0, 1'b0);

        // async reset with MemWriteM high: addi ; sw ; sub
        do_reset();
        set_d(ADDI, 0, 0, 1, 1, 0);
        step();
        set_d(SW, 0, 3, 4, 4, 0);
        step();
        set_d(R, FSUB, 5, 6, 7, 0);
        step();
        chk("pre_reset", {mem_write_m, reg_write_w, alu_e}, {1'b1, 1'b1, 3'b110});
        #2 rst = 1'b1;
        clear_pipes();
        #1;
        chk("async_reset", {mem_write_m, reg_write_w, alu_e}, 5'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("post_reset_load", {alu_e, alu_src_e, reg_dst_e}, {3'b110, 1'b0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
